// File: rtl/cbus_ram_responder_pkg.sv
// Shared cbus types plus the responder FSM state encoding.
package cbus_ram_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_type_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2
    } cbus_resp_state_t;

endpackage

// File: rtl/cbus_ram_responder_ram.sv
// RAM_SinglePort: word-organised single-port RAM with per-byte write strobes.
module RAM_SinglePort #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 64,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 0
) (
    input  logic                             clk,
    input  logic                             en,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH-1:0]            rdata
);
    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Byte-masked write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (strobe[b]) begin
                    mem[addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign rdata = mem[addr];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_r;
            // Registered read path for single-cycle latency builds.
            always_ff @(posedge clk) begin
                rdata_r <= mem[addr];
            end
            assign rdata = rdata_r;
        end
    endgenerate

endmodule

// File: rtl/cbus_ram_responder.sv
// cbus memory-side responder backed by on-chip RAM.
// Optional CBUS_RESP_BACKPRESSURE_EN inserts a stall cycle between burst beats.
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    cbus_resp_state_t     state_r;
    logic [ADDR_BITS-1:0] word_r;
    logic [3:0]           len_r;
    logic [3:0]           beat_cnt_r;
    logic [LAT_W-1:0]     lat_cnt_r;
    logic                 is_write_r;
    logic                 incr_r;
    logic                 ready_r;
    logic                 last_r;

    logic                 beat_act_s;
    logic                 we_s;
    logic [ADDR_BITS-1:0] beat_addr_s;
    logic [63:0]          rdata_s;
    logic                 unused_s;

    // A dropped valid cancels the beat in the same cycle, so no write slips through.
    assign beat_act_s  = ready_r & creq.valid;
    assign we_s        = beat_act_s & is_write_r;
    assign beat_addr_s = incr_r ? (word_r + ADDR_BITS'(beat_cnt_r)) : word_r;
    assign unused_s    = ^{creq.size, creq.addr[31:ADDR_BITS+3], creq.addr[2:0]};

    // Request/latency/beat sequencing with registered handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            word_r     <= '0;
            len_r      <= 4'd0;
            beat_cnt_r <= 4'd0;
            lat_cnt_r  <= '0;
            is_write_r <= 1'b0;
            incr_r     <= 1'b0;
            ready_r    <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    last_r  <= 1'b0;
                    if (creq.valid) begin
                        word_r     <= creq.addr[ADDR_BITS+2:3];
                        is_write_r <= creq.is_write;
                        len_r      <= creq.len;
                        incr_r     <= (creq.burst != AXI_BURST_FIXED);
                        beat_cnt_r <= 4'd0;
                        lat_cnt_r  <= '0;
                        if (LATENCY == 0) begin
                            state_r <= BEAT;
                            ready_r <= 1'b1;
                            last_r  <= (creq.len == MLEN1);
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!creq.valid) begin
                        state_r <= IDLE;
                    end else if (lat_cnt_r == LAT_MAX) begin
                        state_r <= BEAT;
                        ready_r <= 1'b1;
                        last_r  <= (len_r == 4'd0);
                    end else begin
                        lat_cnt_r <= lat_cnt_r + LAT_W'(1);
                    end
                end
                BEAT: begin
                    if (!creq.valid) begin
                        state_r <= IDLE;
                        ready_r <= 1'b0;
                        last_r  <= 1'b0;
                    end else if (ready_r) begin
                        if (last_r) begin
                            state_r <= IDLE;
                            ready_r <= 1'b0;
                            last_r  <= 1'b0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 4'd1;
`ifdef CBUS_RESP_BACKPRESSURE_EN
                            ready_r    <= 1'b0;
                            last_r     <= 1'b0;
`else
                            ready_r    <= 1'b1;
                            last_r     <= ((beat_cnt_r + 4'd1) == len_r);
`endif
                        end
                    end else begin
                        ready_r <= 1'b1;
                        last_r  <= (beat_cnt_r == len_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    last_r  <= 1'b0;
                end
            endcase
        end
    end

    RAM_SinglePort #(
        .ADDR_WIDTH  (ADDR_BITS),
        .DATA_WIDTH  (64),
        .BYTE_WIDTH  (8),
        .READ_LATENCY(0)
    ) u_ram (
        .clk   (clk),
        .en    (we_s),
        .addr  (beat_addr_s),
        .strobe(creq.strobe),
        .wdata (creq.data),
        .rdata (rdata_s)
    );

    // Response assembly; read data is only driven during an active beat.
    always_comb begin
        cresp       = '0;
        cresp.ready = beat_act_s;
        cresp.last  = last_r & beat_act_s;
        if (beat_act_s) begin
            cresp.data = rdata_s;
        end else begin
            cresp.data = 64'd0;
        end
    end

endmodule

// File: doc/cbus_ram_responder.md
Name: cbus_ram_responder

Overview:
- Responder (memory side) of the cbus protocol: accepts `cbus_req_t`, returns `cbus_resp_t`.
- Backs the cbus with a word-organised on-chip RAM.
- Replaces the external memory model for cache and uncached-path unit tests; sits directly on the cache's cbus port.
- Supports single and burst transfers, INCR and FIXED bursts, byte-strobed writes, and a programmable first-beat latency.

Parameters:
- ADDR_BITS, 12, number of word-address bits; RAM depth is 2^ADDR_BITS 64-bit words.
- LATENCY, 2, idle cycles between accepting a request and the first beat (0 allowed).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- creq  input  $bits(cbus_req_t)  valid, is_write, size, addr, strobe, data, len, burst from the initiator.
- cresp  output  $bits(cbus_resp_t)  ready, last, data to the initiator.

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high.
- Reset: state=IDLE; cresp.ready=0, cresp.last=0, cresp.data=0; beat and latency counters 0. RAM contents are not affected by reset (zero at simulation start).
- Word index = creq.addr[ADDR_BITS+2:3]; upper address bits are ignored (aliasing).
- Beats = len+1 (MLEN1 gives 1 beat, MLEN16 gives 16).
- States:
  - IDLE: if creq.valid, latch addr, is_write, len, burst. Go to WAIT if LATENCY>0, else BEAT. The initiator may hold valid high continuously across back-to-back transactions. The cycle after last is IDLE and samples the new request.
  - WAIT: latency counter counts to LATENCY, then BEAT. Outputs stay 0.
  - BEAT: ready=1 each cycle; beat counter increments per cycle; last=1 when counter==len. After last, go to IDLE.
- Beat address:
  - INCR: latched word index + beat counter, wrapping modulo 2^ADDR_BITS.
  - FIXED: latched word index for all beats.
- Read beat: cresp.data = RAM[beat address] combinationally in the same cycle ready=1; data=0 when ready=0.
- Write beat: in each cycle with ready=1, RAM[beat address] is byte-written with live creq.data under live creq.strobe. Data and strobe are not latched, because the initiator advances its data on ready.
- size is not interpreted. Narrow accesses rely on strobe; reads return the full word.
- creq.valid low in WAIT or BEAT (protocol violation/abort): return to IDLE next edge; no further RAM writes; ready and last stay 0 from that cycle.
- Reset asserted mid-burst: outputs drop immediately (async). Writes already committed stay; no partial-cycle write.
- Read latency from request: LATENCY+1 cycles to the first beat. Burst total: LATENCY+1+len cycles.

Optional Feature:
- Macro CBUS_RESP_BACKPRESSURE_EN.
- Defined: in BEAT, one stall cycle (ready=0, last=0, no write, counter held) is inserted after every accepted beat except the last. A 16-beat burst then occupies 31 BEAT cycles.
- Undefined: ready is held high for the whole burst, as described above.

Decomposition:
- Shared package (common): existing `cbus_req_t`, `cbus_resp_t`, `mlen_t`, `axi_burst_type_t` and MLEN/AXI_BURST constants.
- New package-level `cbus_resp_state_t` enum {IDLE, WAIT, BEAT}.
- Storage is the existing RAM_SinglePort, one instance: ADDR_WIDTH=ADDR_BITS, DATA_WIDTH=64, BYTE_WIDTH=8, READ_LATENCY=0.
- No further sub-modules.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle during a BEAT -> ready=0, last=0, data=0 immediately; next request served normally.
2. Single write then read:
   - Write addr 0x8000_0040, MLEN1, strobe 0x0F, data 0x1122_3344_5566_7788 -> ready and last in cycle 3 (LATENCY=2).
   - Read of the same address -> data 0x0000_0000_5566_7788.
3. INCR burst:
   - Write MLEN16 at 0x8000_0000 with data i on beat i -> 16 ready cycles, last on beat 15.
   - Read back INCR -> beats return 0..15 in order.
4. Back-to-back with valid held high:
   - Writeback burst to 0x8000_0100 immediately followed by read burst to 0x8000_0200 (no valid gap) -> read starts LATENCY+1 cycles after the write's last; write data intact.
5. FIXED burst and wrap:
   - FIXED read MLEN1 at 0x0000_0010 -> single beat.
   - INCR MLEN16 at word index 2^ADDR_BITS-2 -> beats 2..15 access words 0..13.
6. Abort, and backpressure when compiled in:
   - Drop valid after beat 3 of a 16-beat write -> words 4..15 unchanged.
   - With CBUS_RESP_BACKPRESSURE_EN -> ready pattern 1,0,1,0..., 31 cycles, same data as scenario 3.
